// File: rtl/bagman_dl_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bagman_dl_ctrl_if
// Description : HPS ioctl download stream plus the ROM write port toward the
//               Bagman core, bundled as one interface.
//               master : download source side (drives ioctl_*, sees dn_*)
//               slave  : download controller  (sees ioctl_*, drives dn_*)
//   ioctl_download  download-active strobe
//   ioctl_wr        byte-valid strobe, one cycle per byte
//   ioctl_addr[24:0] byte address within the current download
//   ioctl_dout[7:0] byte data
//   ioctl_index[7:0] download target index
//   dn_addr[16:0]   ROM write address to core
//   dn_data[7:0]    ROM write data to core
//   dn_wr           ROM write strobe, one-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface bagman_dl_ctrl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output dn_addr, dn_data, dn_wr
  );
endinterface
`default_nettype wire

// File: rtl/bagman_dl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bagman_dl_ctrl
// Description : Download sequencer/router between the HPS ioctl stream and
//               the Bagman core. Index 0 bytes go to the core ROM port,
//               index 1 selects the board variant (mod flags), index 254
//               fills the 8-byte DIP bank. Holds the core in reset until a
//               complete ROM image has loaded, then releases it after
//               RST_HOLD cycles.
// Ports       : clk_sys, reset (sync, active high), bus (ioctl_* in, dn_* out),
//               user_reset, mod_sbag/mod_pick/mod_squa, dipsw[63:0],
//               core_reset, rom_ok, rom_ovf, rom_sum[7:0]
// Options     : DL_CHECKSUM_EN - when defined, rom_ok also requires the
//               8-bit additive ROM checksum to equal ROM_SUM; when undefined
//               rom_sum reads 0 and no adder is built.
// Revision    : 1.0 - initial release
// ============================================================================
module bagman_dl_ctrl #(
  parameter int          ROM_BYTES = 98304,
  parameter int          RST_HOLD  = 16,
  parameter logic [7:0]  ROM_SUM   = 8'h00
) (
  input  wire logic        clk_sys,
  input  wire logic        reset,
  bagman_dl_ctrl_if.slave  bus,
  input  wire logic        user_reset,
  output logic             mod_sbag,
  output logic             mod_pick,
  output logic             mod_squa,
  output logic [63:0]      dipsw,
  output logic             core_reset,
  output logic             rom_ok,
  output logic             rom_ovf,
  output logic [7:0]       rom_sum
);

  localparam logic [7:0]  IDX_ROM  = 8'd0;
  localparam logic [7:0]  IDX_MOD  = 8'd1;
  localparam logic [7:0]  IDX_DIP  = 8'd254;
  localparam int          HOLD_W   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [24:0] ROM_LIM  = 25'(ROM_BYTES);
  // One bit wider than the address so repeated addresses cannot wrap it
  // back onto ROM_BYTES.
  localparam logic [17:0] ROM_CNT  = 18'(ROM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_ROM = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               dl_prev_q;
  logic [7:0]         idx_q, idx_d;
  logic [17:0]        cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [16:0]        dn_addr_q, dn_addr_d;
  logic [7:0]         dn_data_q, dn_data_d;
  logic               dn_wr_q, dn_wr_d;
  logic [7:0]         variant_q, variant_d;
  logic               sbag_q, sbag_d, pick_q, pick_d, squa_q, squa_d;
  logic [63:0]        dipsw_q, dipsw_d;
  logic               core_reset_q, core_reset_d;
  logic               rom_ok_q, rom_ok_d;
  logic               rom_ovf_q, rom_ovf_d;
`ifdef DL_CHECKSUM_EN
  logic [7:0]         rom_sum_q, rom_sum_d;
`endif

  logic rise, fall, accept, start_rom, in_range, load_good;

  always_comb begin
    rise      = bus.ioctl_download & ~dl_prev_q;
    fall      = ~bus.ioctl_download & dl_prev_q;
    accept    = bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_index == idx_q);
    start_rom = rise & (bus.ioctl_index == IDX_ROM);
    in_range  = bus.ioctl_addr < ROM_LIM;
`ifdef DL_CHECKSUM_EN
    load_good = (cnt_q == ROM_CNT) & ~rom_ovf_q & (rom_sum_q == ROM_SUM);
`else
    load_good = (cnt_q == ROM_CNT) & ~rom_ovf_q;
`endif

    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    dn_wr_d   = 1'b0;
    variant_d = variant_q;
    dipsw_d   = dipsw_q;
    rom_ok_d  = rom_ok_q;
    rom_ovf_d = rom_ovf_q;
`ifdef DL_CHECKSUM_EN
    rom_sum_d = rom_sum_q;
`endif

    if (rise) begin
      idx_d = bus.ioctl_index;
    end

    // Non-ROM targets are serviced regardless of the sequencer state.
    if (accept && idx_q == IDX_MOD) begin
      variant_d = bus.ioctl_dout;
    end
    if (accept && idx_q == IDX_DIP && bus.ioctl_addr[24:3] == 22'd0) begin
      dipsw_d[{bus.ioctl_addr[2:0], 3'b000} +: 8] = bus.ioctl_dout;
    end

    sbag_d = (variant_q == 8'd1);
    pick_d = (variant_q == 8'd2);
    squa_d = (variant_q == 8'd3);

    case (state_q)
      ST_IDLE: begin
      end
      ST_LOAD_ROM: begin
        if (fall) begin
          rom_ok_d = load_good;
          state_d  = load_good ? ST_HOLD : ST_IDLE;
          hold_d   = HOLD_LOAD;
        end else if (accept && idx_q == IDX_ROM) begin
          if (in_range) begin
            dn_addr_d = bus.ioctl_addr[16:0];
            dn_data_d = bus.ioctl_dout;
            dn_wr_d   = 1'b1;
            cnt_d     = cnt_q + 18'd1;
`ifdef DL_CHECKSUM_EN
            rom_sum_d = rom_sum_q + bus.ioctl_dout;
`endif
          end else begin
            rom_ovf_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A held user_reset keeps reloading, so the hold time counts from
        // its release.
        if (user_reset) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (user_reset) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new ROM download preempts every state.
    if (start_rom) begin
      state_d   = ST_LOAD_ROM;
      cnt_d     = '0;
      rom_ok_d  = 1'b0;
      rom_ovf_d = 1'b0;
`ifdef DL_CHECKSUM_EN
      rom_sum_d = '0;
`endif
    end

    core_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      // Track the live strobe so a download already in flight is not
      // mistaken for a new one once reset drops.
      dl_prev_q    <= bus.ioctl_download;
      idx_q        <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_wr_q      <= 1'b0;
      variant_q    <= '0;
      sbag_q       <= 1'b0;
      pick_q       <= 1'b0;
      squa_q       <= 1'b0;
      dipsw_q      <= '0;
      core_reset_q <= 1'b1;
      rom_ok_q     <= 1'b0;
      rom_ovf_q    <= 1'b0;
`ifdef DL_CHECKSUM_EN
      rom_sum_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dl_prev_q    <= bus.ioctl_download;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      variant_q    <= variant_d;
      sbag_q       <= sbag_d;
      pick_q       <= pick_d;
      squa_q       <= squa_d;
      dipsw_q      <= dipsw_d;
      core_reset_q <= core_reset_d;
      rom_ok_q     <= rom_ok_d;
      rom_ovf_q    <= rom_ovf_d;
`ifdef DL_CHECKSUM_EN
      rom_sum_q    <= rom_sum_d;
`endif
    end
  end

  assign bus.dn_addr = dn_addr_q;
  assign bus.dn_data = dn_data_q;
  assign bus.dn_wr   = dn_wr_q;
  assign mod_sbag    = sbag_q;
  assign mod_pick    = pick_q;
  assign mod_squa    = squa_q;
  assign dipsw       = dipsw_q;
  assign core_reset  = core_reset_q;
  assign rom_ok      = rom_ok_q;
  assign rom_ovf     = rom_ovf_q;
`ifdef DL_CHECKSUM_EN
  assign rom_sum     = rom_sum_q;
`else
  assign rom_sum     = 8'h00;
  logic unused_rom_sum;
  assign unused_rom_sum = ^ROM_SUM;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bagman_dl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bagman_dl_ctrl
// Description : Self-checking bench for bagman_dl_ctrl. Uses a 64-byte ROM
//               image (data = addr[7:0], checksum 8'hE0) to keep runs short.
//               Honours DL_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bagman_dl_ctrl;

  localparam int         N_ROM    = 64;
  localparam int         N_HOLD   = 16;
  localparam logic [7:0] GOOD_SUM = 8'hE0;
  localparam int         HOLD_MAX = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        user_reset;
  logic        mod_sbag, mod_pick, mod_squa;
  logic [63:0] dipsw;
  logic        core_reset, rom_ok, rom_ovf;
  logic [7:0]  rom_sum;

  int tests = 0;
  int fails = 0;
  int dn_cnt = 0;

  bagman_dl_ctrl_if bus ();

  bagman_dl_ctrl #(
    .ROM_BYTES (N_ROM),
    .RST_HOLD  (N_HOLD),
    .ROM_SUM   (GOOD_SUM)
  ) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .user_reset (user_reset),
    .mod_sbag   (mod_sbag),
    .mod_pick   (mod_pick),
    .mod_squa   (mod_squa),
    .dipsw      (dipsw),
    .core_reset (core_reset),
    .rom_ok     (rom_ok),
    .rom_ovf    (rom_ovf),
    .rom_sum    (rom_sum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dn_wr === 1'b1) dn_cnt <= dn_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  latch_idx;
    logic [7:0]  wr_idx;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [2:0]  exp_mod;   // {squa, pick, sbag}
    logic [63:0] exp_dip;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " dn_addr"},    64'(bus.dn_addr), 64'd0);
    check({tag, " dn_data"},    64'(bus.dn_data), 64'd0);
    check({tag, " dn_wr"},      64'(bus.dn_wr), 64'd0);
    check({tag, " mods"},       64'({mod_squa, mod_pick, mod_sbag}), 64'd0);
    check({tag, " dipsw"},      dipsw, 64'd0);
    check({tag, " core_reset"}, 64'(core_reset), 64'd1);
    check({tag, " rom_ok"},     64'(rom_ok), 64'd0);
    check({tag, " rom_ovf"},    64'(rom_ovf), 64'd0);
    check({tag, " rom_sum"},    64'(rom_sum), 64'd0);
  endtask

  // One ROM byte, with a spacer cycle; checks the pulse one cycle later.
  task automatic rom_byte(input int a, input logic [7:0] d, input bit exp_wr);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr = 1'b0;
    check("dn_wr pulse", 64'(bus.dn_wr), 64'(exp_wr));
    if (exp_wr) begin
      check("dn_addr", 64'(bus.dn_addr), 64'(a[16:0]));
      check("dn_data", 64'(bus.dn_data), 64'(d));
    end
    tick();
    check("dn_wr single", 64'(bus.dn_wr), 64'd0);
  endtask

  // Full index-0 download of n bytes; byte 0 XORed with corrupt.
  task automatic rom_load(input int n, input logic [7:0] corrupt,
                          input bit exp_ok, input bit count_hold);
    logic [7:0] d;
    logic [7:0] sum;
    int         base;
    int         hold;
    sum  = 8'h00;
    base = dn_cnt;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    check("load core_reset", 64'(core_reset), 64'd1);
    for (int i = 0; i < n; i++) begin
      d = 8'(i) ^ ((i == 0) ? corrupt : 8'h00);
      if (i < N_ROM) sum = sum + d;
      rom_byte(i, d, i < N_ROM);
    end
    bus.ioctl_download = 1'b0;
    tick();
    check("rom_ok", 64'(rom_ok), 64'(exp_ok));
    check("rom_ovf", 64'(rom_ovf), 64'(n > N_ROM));
`ifdef DL_CHECKSUM_EN
    check("rom_sum", 64'(rom_sum), 64'(sum));
`else
    check("rom_sum", 64'(rom_sum), 64'd0);
`endif
    check("dn_wr count", 64'(dn_cnt - base), 64'((n < N_ROM) ? n : N_ROM));
    if (count_hold) begin
      hold = 0;
      while (core_reset && hold < HOLD_MAX) begin
        hold++;
        tick();
      end
      check("hold cycles", 64'(hold), exp_ok ? 64'(N_HOLD) : 64'(HOLD_MAX));
      if (exp_ok) check("core_reset released", 64'(core_reset), 64'd0);
    end
  endtask

  task automatic dl_one(input vec_t v, input int k);
    int base;
    base = dn_cnt;
    bus.ioctl_index    = v.latch_idx;
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_index = v.wr_idx;
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_addr  = v.addr;
    bus.ioctl_dout  = v.data;
    tick();
    bus.ioctl_wr    = 1'b0;
    bus.ioctl_index = v.latch_idx;
    tick();
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    check($sformatf("vec%0d mods", k), 64'({mod_squa, mod_pick, mod_sbag}), 64'(v.exp_mod));
    check($sformatf("vec%0d dipsw", k), dipsw, v.exp_dip);
    check($sformatf("vec%0d core_reset", k), 64'(core_reset), 64'd0);
    check($sformatf("vec%0d dn_wr", k), 64'(dn_cnt - base), 64'd0);
  endtask

  initial begin
    int base;
    int hold;

    vecs[0] = '{8'd1,   8'd1,   25'd0, 8'h03, 3'b100, 64'h0};
    vecs[1] = '{8'd254, 8'd254, 25'd0, 8'hA5, 3'b100, 64'h0000_0000_0000_00A5};
    vecs[2] = '{8'd254, 8'd254, 25'd7, 8'h3C, 3'b100, 64'h3C00_0000_0000_00A5};
    vecs[3] = '{8'd254, 8'd254, 25'd8, 8'hFF, 3'b100, 64'h3C00_0000_0000_00A5};
    vecs[4] = '{8'd1,   8'd1,   25'd0, 8'h01, 3'b001, 64'h3C00_0000_0000_00A5};
    vecs[5] = '{8'd1,   8'd1,   25'd5, 8'h02, 3'b010, 64'h3C00_0000_0000_00A5};
    vecs[6] = '{8'd254, 8'd254, 25'd3, 8'h5A, 3'b010, 64'h3C00_0000_5A00_00A5};
    vecs[7] = '{8'd1,   8'd254, 25'd1, 8'h77, 3'b010, 64'h3C00_0000_5A00_00A5};
    vecs[8] = '{8'd1,   8'd1,   25'd0, 8'h07, 3'b000, 64'h3C00_0000_5A00_00A5};
    vecs[9] = '{8'd1,   8'd1,   25'd0, 8'h03, 3'b100, 64'h3C00_0000_5A00_00A5};

    reset              = 1'b1;
    user_reset         = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;
    tick(); tick(); tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Good load, release after the hold period.
    rom_load(N_ROM, 8'h00, 1'b1, 1'b1);

    // Variant / DIP vectors while the core runs.
    for (int k = 0; k < 10; k++) dl_one(vecs[k], k);

    // user_reset held 5 cycles.
    user_reset = 1'b1;
    tick();
    check("user_reset asserts core_reset", 64'(core_reset), 64'd1);
    tick(); tick(); tick(); tick();
    user_reset = 1'b0;
    hold = 0;
    while (core_reset && hold < HOLD_MAX) begin
      hold++;
      tick();
    end
    check("user_reset hold cycles", 64'(hold), 64'(N_HOLD));

    // Oversized image.
    rom_load(N_ROM + 2, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a download.
    bus.ioctl_index    = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) rom_byte(i, 8'(i), 1'b1);
    reset = 1'b1;
    tick();
    check_reset_vals("mid reset");
    reset = 1'b0;
    base = dn_cnt;
    for (int i = 10; i < 20; i++) rom_byte(i, 8'(i), 1'b0);
    bus.ioctl_download = 1'b0;
    tick(); tick();
    check("aborted dn_wr count", 64'(dn_cnt - base), 64'd0);
    check("aborted core_reset", 64'(core_reset), 64'd1);
    check("aborted rom_ok", 64'(rom_ok), 64'd0);

    // Recovery load, then a second load started from HOLD.
    rom_load(N_ROM, 8'h00, 1'b1, 1'b0);
    tick(); tick();
    check("in hold core_reset", 64'(core_reset), 64'd1);
    rom_load(N_ROM, 8'h00, 1'b1, 1'b1);

`ifdef DL_CHECKSUM_EN
    rom_load(N_ROM, 8'h01, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bagman_dl_ctrl.md
Name: bagman_dl_ctrl

Overview:
- Download sequencer and router between the HPS ioctl stream and the Bagman core.
- Routes ROM bytes (index 0) to the core's dn_* port, latches the board-variant byte (index 1) and decodes it into mod flags.
- Stores the 8-byte DIP bank (index 254).
- Owns the core reset: holds the core in reset until a valid ROM image has loaded, then releases it after a fixed settle period.

Parameters:
- ROM_BYTES, 98304, number of bytes a complete ROM image must contain; must fit in 17 bits.
- RST_HOLD, 16, cycles core_reset stays high after a good load or after a user reset; must be ≥1.
- ROM_SUM, 8'h00, expected 8-bit additive checksum; used only with DL_CHECKSUM_EN.

Ports:
- clk_sys  in  1  system clock (12 MHz); all logic on its rising edge.
- reset  in  1  synchronous, active-high block reset.
- ioctl_download  in  1  HPS download-active strobe.
- ioctl_wr  in  1  byte-valid strobe, one cycle per byte.
- ioctl_addr  in  25  byte address within the current download.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  download target index.
- user_reset  in  1  menu/button reset request, level.
- dn_addr  out  17  ROM write address to core.
- dn_data  out  8  ROM write data to core.
- dn_wr  out  1  ROM write strobe, one-cycle pulse.
- mod_sbag  out  1  variant byte == 1.
- mod_pick  out  1  variant byte == 2.
- mod_squa  out  1  variant byte == 3.
- dipsw  out  64  DIP bank; byte n = dipsw[8n+7:8n].
- core_reset  out  1  reset to the Bagman core.
- rom_ok  out  1  last ROM download was complete and valid.
- rom_ovf  out  1  sticky; a ROM byte arrived at an address ≥ ROM_BYTES.
- rom_sum  out  8  running ROM checksum.

Behaviour:

Reset values (reset=1, synchronous):
- Outputs: dn_addr=0, dn_data=0, dn_wr=0, all mod flags 0, dipsw=0, core_reset=1, rom_ok=0, rom_ovf=0, rom_sum=0.
- Internal state: state=IDLE, byte counter=0, latched index=0, variant byte=0.
- Reset mid-download aborts the load. Later writes of that download are ignored until the next rising edge of ioctl_download.

Download framing:
- The rising edge of ioctl_download (registered previous value) latches ioctl_index.
- A write is accepted only if ioctl_download=1, ioctl_wr=1, and ioctl_index equals the latched index. Any other write is dropped silently.

States:
- IDLE: core_reset=1. A rising edge with index 0 → LOAD_ROM.
- LOAD_ROM: core_reset=1.
  - On entry: counter=0, rom_sum=0, rom_ovf=0, rom_ok=0.
  - Accepted write with addr < ROM_BYTES: next cycle dn_addr=addr[16:0], dn_data=dout, dn_wr=1 (latency 1, single-cycle pulse). Counter +1; rom_sum += dout (mod 256).
  - Accepted write with addr ≥ ROM_BYTES: no dn_wr; rom_ovf=1.
  - Falling edge of ioctl_download: rom_ok = (counter==ROM_BYTES) && !rom_ovf. Next state is HOLD if rom_ok else IDLE.
- HOLD: core_reset=1; a down-counter is loaded with RST_HOLD-1 on entry and decrements; at 0 → RUN. Exactly RST_HOLD cycles with core_reset high in HOLD.
- RUN: core_reset=0.
  - user_reset=1 → HOLD; the counter restarts, so reset lasts RST_HOLD cycles after user_reset falls.
  - A rising edge with index 0 → LOAD_ROM.

Non-ROM indices (processed in every state, never touch core_reset or dn_wr):
- Index 1: variant byte <= dout on every accepted write (last write wins). Mod flags are registered decodes of the variant byte, valid 1 cycle after the byte updates; exactly one or none is set.
- Index 254: accepted write with addr[24:3]==0 sets dipsw byte addr[2:0] = dout, visible next cycle. Other addresses are ignored.

Simultaneous events and edge cases:
- user_reset during LOAD_ROM/IDLE has no effect.
- reset has priority over everything.
- A back-to-back ROM download restarts LOAD_ROM cleanly.
- A rising edge of ioctl_download with index 0 while in HOLD → LOAD_ROM.

Optional Feature:
DL_CHECKSUM_EN:
- Defined: the rom_ok condition additionally requires rom_sum==ROM_SUM at download end; a mismatch sends the FSM to IDLE.
- Undefined: rom_sum is tied to 0, the checksum adder is not built, and rom_ok ignores checksums.

Test Plan:
- Reset, then a full index-0 download of ROM_BYTES bytes (data = addr[7:0]):
  - A dn_wr pulse 1 cycle after each ioctl_wr, with matching addr/data.
  - At the falling edge rom_ok=1; core_reset stays high exactly 16 cycles, then 0.
- ROM download of ROM_BYTES+2 bytes:
  - Only ROM_BYTES dn_wr pulses; rom_ovf=1, rom_ok=0.
  - FSM returns to IDLE with core_reset held 1.
- Index-1 download of byte 3 while in RUN:
  - mod_squa=1, mod_sbag=mod_pick=0 within 2 cycles.
  - core_reset stays 0 and no dn_wr.
- Index-254 writes: addr0=8'hA5, addr7=8'h3C, addr8=8'hFF:
  - dipsw[7:0]=A5, dipsw[63:56]=3C.
  - The addr-8 write is ignored.
- In RUN, pulse user_reset for 5 cycles → core_reset rises, then falls 16 cycles after user_reset drops.
- Assert reset midway through a ROM download:
  - Outputs return to reset values.
  - Remaining writes produce no dn_wr until a new download edge.
- With DL_CHECKSUM_EN and ROM_SUM wrong → rom_ok=0, core_reset stays 1.
